// File: rtl/riscv_instr_fetch_queue.sv
// rtl/riscv_instr_fetch_queue.sv - instruction fetch queue with halfword-granular instruction assembly
module riscv_instr_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        hwloop_i,
  input  logic [31:0] hwloop_target_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        is_hwlp_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORT} state_t;

  state_t         r_state;
  logic           r_abort;
  logic           r_instr_req;
  logic           r_busy;
  logic [31:0]    r_instr_addr;
  logic [31:0]    r_fetch_addr;
  logic [31:0]    r_out_addr;
  logic           r_is_hwlp;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_fifo [DEPTH];

  state_t         w_state_nxt;
  logic           w_abort_nxt;
  logic           w_issue;
  logic           w_push;
  logic           w_gnt_adv;
  logic [31:0]    w_issue_addr;
  logic [31:0]    w_e0;
  logic [31:0]    w_e1;
  logic           w_valid;
  logic [31:0]    w_rdata;
  logic           w_fire;
  logic           w_inc4;
  logic           w_pop;
  logic           w_hwlp;
  logic           w_redir;
  logic [31:0]    w_target;
  logic [CW-1:0]  w_wr_idx;

  // Assemble the instruction at out_addr from the two oldest buffered words
  always_comb begin
    w_e0    = r_fifo[0];
    w_e1    = r_fifo[1];
    w_valid = 1'b0;
    w_rdata = w_e0;
    if (!r_out_addr[1]) begin
      w_valid = (r_count != '0);
    end else if (w_e0[17:16] != 2'b11) begin
      w_valid = (r_count != '0);
      w_rdata = {(r_count >= TWO) ? w_e1[15:0] : 16'h0, w_e0[31:16]};
    end else begin
      w_valid = (r_count >= TWO);
      w_rdata = {w_e1[15:0], w_e0[31:16]};
    end
  end

  assign w_fire       = w_valid & ready_i;
  assign w_inc4       = (w_rdata[1:0] == 2'b11);
  assign w_hwlp       = hwloop_i & w_fire & ~branch_i;
  assign w_redir      = branch_i | w_hwlp;
  assign w_target     = branch_i ? addr_i : hwloop_target_i;
  // Advancing out of the upper halfword, or by a full word, always leaves the head word behind
  assign w_pop        = w_fire & ~w_redir & (r_out_addr[1] | w_inc4);
  assign w_issue_addr = w_redir ? {w_target[31:2], 2'b00} : r_fetch_addr;
  assign w_wr_idx     = r_count - CW'(w_pop);

  // Next fetch state: a new request only when the FIFO can absorb its response
  always_comb begin
    w_state_nxt = r_state;
    w_abort_nxt = r_abort;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    w_gnt_adv   = 1'b0;
    case (r_state)
      IDLE: w_issue = req_i & (w_redir | (r_count < DEPTH_C));
      WAIT_GNT: begin
        if (instr_gnt_i) begin
          w_abort_nxt = 1'b0;
          if (r_abort | w_redir) begin
            w_state_nxt = WAIT_ABORT;
          end else begin
            w_state_nxt = WAIT_RVALID;
            w_gnt_adv   = 1'b1;
          end
        end else if (w_redir) begin
          w_abort_nxt = 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          w_push      = ~w_redir;
          w_state_nxt = IDLE;
          w_issue     = req_i & (w_redir | (r_count < DEPTH_M1));
        end else if (w_redir) begin
          w_state_nxt = WAIT_ABORT;
        end
      end
      WAIT_ABORT: begin
        if (instr_rvalid_i) begin
          w_state_nxt = IDLE;
          w_issue     = req_i & (w_redir | (r_count < DEPTH_C));
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_issue) w_state_nxt = WAIT_GNT;
  end

  // Fetch FSM state and its registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_abort      <= 1'b0;
      r_instr_req  <= 1'b0;
      r_busy       <= 1'b0;
      r_instr_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_abort     <= w_abort_nxt;
      r_instr_req <= (w_state_nxt == WAIT_GNT);
      r_busy      <= (w_state_nxt != IDLE);
      if (w_issue) r_instr_addr <= w_issue_addr;
    end
  end

  // Fetch pointer, output PC and hardware-loop marker; redirects take priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_addr <= '0;
      r_out_addr   <= '0;
      r_is_hwlp    <= 1'b0;
    end else begin
      if (w_redir) r_fetch_addr <= {w_target[31:2], 2'b00};
      else if (w_gnt_adv) r_fetch_addr <= r_fetch_addr + 32'd4;
      if (w_redir) r_out_addr <= w_target;
      else if (w_fire) r_out_addr <= r_out_addr + (w_inc4 ? 32'd4 : 32'd2);
      if (branch_i) r_is_hwlp <= 1'b0;
      else if (w_hwlp) r_is_hwlp <= 1'b1;
      else if (w_fire) r_is_hwlp <= 1'b0;
    end
  end

  // Shift-register FIFO: head always at index 0, flushed on any redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
    end else if (w_redir) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_fifo[i] <= r_fifo[i+1];
      end
      if (w_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == w_wr_idx) r_fifo[i] <= instr_rdata_i;
        end
      end
    end
  end

  assign valid_o      = w_valid;
  assign rdata_o      = w_rdata;
  assign addr_o       = r_out_addr;
  assign is_hwlp_o    = r_is_hwlp;
  assign instr_req_o  = r_instr_req;
  assign instr_addr_o = r_instr_addr;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_riscv_instr_fetch_queue.sv
// tb/tb_riscv_instr_fetch_queue.sv - directed bench for riscv_instr_fetch_queue
module tb_riscv_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        hwloop_i = 1'b0;
  logic [31:0] hwloop_target_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        is_hwlp_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  int n_cmp = 0;
  int n_fail = 0;

  riscv_instr_fetch_queue #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .hwloop_i(hwloop_i), .hwloop_target_i(hwloop_target_i), .ready_i(ready_i),
    .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .is_hwlp_o(is_hwlp_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Memory image: a few hand-placed words, everything else is {addr[15:0], 16'h0013}
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0080: return 32'h00A0_0093;
      32'h0000_0100: return 32'h0093_4501;
      32'h0000_0104: return 32'h1234_00A0;
      32'h0000_0200: return 32'h4501_4505;
      default:       return {a[15:0], 16'h0013};
    endcase
  endfunction

  // Memory responder: grant in the request cycle, rvalid rv_delay cycles after the one following grant
  bit          resp_active = 1'b0;
  int          resp_wait = 0;
  int          rv_delay = 0;
  int          n_gnt = 0;
  logic [31:0] resp_addr = '0;

  assign instr_gnt_i    = instr_req_o;
  assign instr_rvalid_i = resp_active && (resp_wait == 0);
  assign instr_rdata_i  = instr_rvalid_i ? mem_rd(resp_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (instr_rvalid_i) resp_active <= 1'b0;
    if (instr_req_o && instr_gnt_i) begin
      resp_active <= 1'b1;
      resp_addr   <= instr_addr_o;
      resp_wait   <= rv_delay;
      n_gnt       <= n_gnt + 1;
    end else if (resp_active && resp_wait > 0) begin
      resp_wait <= resp_wait - 1;
    end
  end

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic settle();
    ready_i  = 1'b0;
    branch_i = 1'b0;
    hwloop_i = 1'b0;
    rv_delay = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid_o); end
    n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", instr_req_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    n_cmp++; if (is_hwlp_o !== 1'b0) begin n_fail++; $display("FAIL rst_hwlp: got %b exp 0", is_hwlp_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", rdata_o); end
    n_cmp++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", addr_o); end
    n_cmp++; if (instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_iaddr: got %h exp 0", instr_addr_o); end
  endtask

  task automatic test_branch_aligned();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h80;
    @(negedge clk);
    branch_i = 1'b0;
    n_cmp++; if (instr_req_o !== 1'b1) begin n_fail++; $display("FAIL al_req_n1: got %b exp 1", instr_req_o); end
    n_cmp++; if (instr_addr_o !== 32'h80) begin n_fail++; $display("FAIL al_iaddr_n1: got %h exp 00000080", instr_addr_o); end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL al_valid_n2: got %b exp 0", valid_o); end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL al_valid_n3: got %b exp 1", valid_o); end
    n_cmp++; if (addr_o !== 32'h80) begin n_fail++; $display("FAIL al_addr: got %h exp 00000080", addr_o); end
    n_cmp++; if (rdata_o !== 32'h00A0_0093) begin n_fail++; $display("FAIL al_rdata: got %h exp 00a00093", rdata_o); end
  endtask

  task automatic test_unaligned();
    int early;
    settle();
    branch_i = 1'b1; addr_i = 32'h102;
    early = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      branch_i = 1'b0;
      if (valid_o) early++;
    end
    n_cmp++; if (early !== 0) begin n_fail++; $display("FAIL ua_early: valid high %0d cycles, exp 0", early); end
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL ua_valid_n5: got %b exp 1", valid_o); end
    n_cmp++; if (addr_o !== 32'h102) begin n_fail++; $display("FAIL ua_addr: got %h exp 00000102", addr_o); end
    n_cmp++; if (rdata_o !== 32'h00A0_0093) begin n_fail++; $display("FAIL ua_rdata: got %h exp 00a00093", rdata_o); end
  endtask

  task automatic test_compressed();
    bit ok;
    settle();
    branch_i = 1'b1; addr_i = 32'h200; ready_i = 1'b1;
    @(negedge clk);
    branch_i = 1'b0;
    wait_valid(20, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL c0_timeout: no valid, exp valid"); end
    n_cmp++; if (addr_o !== 32'h200) begin n_fail++; $display("FAIL c0_addr: got %h exp 00000200", addr_o); end
    n_cmp++; if (rdata_o !== 32'h4501_4505) begin n_fail++; $display("FAIL c0_rdata: got %h exp 45014505", rdata_o); end
    wait_valid(20, ok);
    n_cmp++; if (addr_o !== 32'h202) begin n_fail++; $display("FAIL c1_addr: got %h exp 00000202", addr_o); end
    n_cmp++; if (rdata_o[15:0] !== 16'h4501) begin n_fail++; $display("FAIL c1_rdata: got %h exp 4501", rdata_o[15:0]); end
    wait_valid(20, ok);
    n_cmp++; if (addr_o !== 32'h204) begin n_fail++; $display("FAIL c2_addr: got %h exp 00000204", addr_o); end
    n_cmp++; if (rdata_o !== 32'h0204_0013) begin n_fail++; $display("FAIL c2_pop: got %h exp 02040013", rdata_o); end
  endtask

  task automatic test_abort();
    bit ok;
    settle();
    rv_delay = 3;
    branch_i = 1'b1; addr_i = 32'h400;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk);
    branch_i = 1'b1; addr_i = 32'h500;
    @(negedge clk);
    branch_i = 1'b0; rv_delay = 0;
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ab_busy: got %b exp 1", busy_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ab_valid: got %b exp 0", valid_o); end
    wait_valid(30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL ab_timeout: no valid, exp valid"); end
    n_cmp++; if (addr_o !== 32'h500) begin n_fail++; $display("FAIL ab_addr: got %h exp 00000500", addr_o); end
    n_cmp++; if (rdata_o !== 32'h0500_0013) begin n_fail++; $display("FAIL ab_rdata: got %h exp 05000013", rdata_o); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] exp_a;
    settle();
    n_gnt = 0;
    branch_i = 1'b1; addr_i = 32'h300;
    @(negedge clk);
    branch_i = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (n_gnt !== 2) begin n_fail++; $display("FAIL st_words: got %0d grants exp 2", n_gnt); end
    n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL st_req_full: got %b exp 0", instr_req_o); end
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_a = 32'h300 + 32'(4 * k);
      if (k == 0) begin
        ok = valid_o;
      end else begin
        wait_valid(20, ok);
      end
      n_cmp++; if (!ok || addr_o !== exp_a) begin n_fail++; $display("FAIL st_addr%0d: got %h exp %h", k, addr_o, exp_a); end
      n_cmp++; if (rdata_o !== mem_rd(exp_a)) begin n_fail++; $display("FAIL st_rdata%0d: got %h exp %h", k, rdata_o, mem_rd(exp_a)); end
    end
  endtask

  task automatic test_hwloop();
    bit ok;
    settle();
    branch_i = 1'b1; addr_i = 32'h600; ready_i = 1'b1;
    @(negedge clk);
    branch_i = 1'b0;
    wait_valid(20, ok);
    n_cmp++; if (!ok || addr_o !== 32'h600) begin n_fail++; $display("FAIL hl_first: got %h exp 00000600", addr_o); end
    hwloop_i = 1'b1; hwloop_target_i = 32'h700;
    @(negedge clk);
    hwloop_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL hl_drop: got %b exp 0", valid_o); end
    wait_valid(20, ok);
    n_cmp++; if (addr_o !== 32'h700) begin n_fail++; $display("FAIL hl_addr: got %h exp 00000700", addr_o); end
    n_cmp++; if (rdata_o !== 32'h0700_0013) begin n_fail++; $display("FAIL hl_rdata: got %h exp 07000013", rdata_o); end
    n_cmp++; if (is_hwlp_o !== 1'b1) begin n_fail++; $display("FAIL hl_flag: got %b exp 1", is_hwlp_o); end
    wait_valid(20, ok);
    n_cmp++; if (addr_o !== 32'h704) begin n_fail++; $display("FAIL hl_next_addr: got %h exp 00000704", addr_o); end
    n_cmp++; if (is_hwlp_o !== 1'b0) begin n_fail++; $display("FAIL hl_clear: got %b exp 0", is_hwlp_o); end
  endtask

  task automatic test_branch_hwloop();
    bit ok;
    settle();
    branch_i = 1'b1; addr_i = 32'h800; ready_i = 1'b1;
    @(negedge clk);
    branch_i = 1'b0;
    wait_valid(20, ok);
    n_cmp++; if (!ok || addr_o !== 32'h800) begin n_fail++; $display("FAIL bh_first: got %h exp 00000800", addr_o); end
    branch_i = 1'b1; addr_i = 32'h900;
    hwloop_i = 1'b1; hwloop_target_i = 32'hA00;
    @(negedge clk);
    branch_i = 1'b0; hwloop_i = 1'b0;
    wait_valid(20, ok);
    n_cmp++; if (addr_o !== 32'h900) begin n_fail++; $display("FAIL bh_addr: got %h exp 00000900", addr_o); end
    n_cmp++; if (rdata_o !== 32'h0900_0013) begin n_fail++; $display("FAIL bh_rdata: got %h exp 09000013", rdata_o); end
    n_cmp++; if (is_hwlp_o !== 1'b0) begin n_fail++; $display("FAIL bh_flag: got %b exp 0", is_hwlp_o); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_branch_aligned();
    test_unaligned();
    test_compressed();
    test_abort();
    test_stall();
    test_hwloop();
    test_branch_hwloop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
